sort_sequencer: RTL and testbench
=================================

SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameters SHALL be: ELEMENT_NUM, default 8, element count per sort; DATA_WIDTH, default 8, element width; LOG2_ELEMENT_NUM, default 3; LOG2_DATA_WIDTH, default 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  load element offered.
REQ-005 in_data  input  DATA_WIDTH  unsigned element value.
REQ-006 in_ready  output  1  sequencer accepts element this cycle.
REQ-007 abort  input  1  synchronous cancel of current job.
REQ-008 eng_rst  output  1  active-high reset to sorting engine.
REQ-009 eng_flag  output  1  engine mode; 1 input/hold, 0 sorting.
REQ-010 eng_bit_addr  input  LOG2_DATA_WIDTH  bit plane requested by engine.
REQ-011 eng_bit_data  output  ELEMENT_NUM  bit plane; bit e = bit eng_bit_addr of element e.
REQ-012 eng_le_addr  input  LOG2_ELEMENT_NUM  index of element emitted by engine.
REQ-013 eng_valid  input  1  eng_le_addr valid this cycle.
REQ-014 out_valid  output  1  sorted result available.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 out_idx  output  LOG2_ELEMENT_NUM  original load index of result.
REQ-017 out_data  output  DATA_WIDTH  element value of result.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, CLEAR, SORT, DRAIN.
REQ-020 IDLE: in_ready=1; first accepted element (in_valid&in_ready) stored at index 0, go LOAD.
REQ-021 LOAD: in_ready=1; element k stored at index k, load counter increments per accept; after accept of index ELEMENT_NUM-1 go CLEAR.
REQ-022 Storage SHALL be a transposed array: plane[b][e] = bit b of element e; eng_bit_data = plane[eng_bit_addr], combinational.
REQ-023 A parallel element array SHALL hold full words for out_data lookup.
REQ-024 CLEAR: lasts exactly 1 cycle, eng_rst=1, eng_flag=1, in_ready=0; next state SORT.
REQ-025 SORT: eng_flag=0, in_ready=0; each cycle with eng_valid=1 pushes eng_le_addr into result FIFO and increments result counter.
REQ-026 Result FIFO depth SHALL be ELEMENT_NUM; it cannot overflow since one job yields exactly ELEMENT_NUM pushes; a push when full SHALL be dropped and not wrap.
REQ-027 When result counter reaches ELEMENT_NUM (counting the push in that cycle) go DRAIN; eng_flag=1 from that next cycle.
REQ-028 FIFO head drives out_valid=~empty, out_idx=head, out_data=element[head]; pop on out_valid&out_ready; push and pop in same cycle SHALL both take effect.
REQ-029 Output is first-result-first-out: engine emission order (descending value; duplicates in engine order).
REQ-030 Results SHALL be poppable during SORT as well as DRAIN.
REQ-031 DRAIN: when FIFO empty (after final pop) go IDLE; in_ready stays 0 until IDLE.
REQ-032 abort=1 in any state: next cycle IDLE, counters and FIFO cleared, eng_flag=1, eng_rst pulsed 1 cycle; stored elements need not be cleared; abort has priority over all other transitions.
REQ-033 eng_valid outside SORT SHALL be ignored.
REQ-034 Outside CLEAR and abort pulse, eng_rst=0; outside SORT, eng_flag=1.

Reset
REQ-035 While rst=0: state IDLE, in_ready=1 after release, eng_rst=1, eng_flag=1, out_valid=0, busy=0, counters 0, FIFO empty, out_idx=0, out_data=0.
REQ-036 Reset assertion mid-job SHALL discard the job immediately; first job after release starts at index 0.

Verification
REQ-037 Load {5,3,7,1,6,2,4,0}, out_ready=1, model engine -> out_idx sequence 2,4,0,6,1,5,3,7, out_data 7,6,5,4,3,2,1,0, then busy=0.
REQ-038 Load all 8 elements = 9, engine emits 8 valids -> exactly 8 results, each value 9, indices a permutation of 0..7.
REQ-039 out_ready=0 throughout SORT -> FIFO holds 8, out_valid=1, no loss; then out_ready=1 -> 8 pops in 8 cycles, IDLE next.
REQ-040 in_valid toggling 1/0 during LOAD -> exactly 8 accepts stored in order; in_ready=0 from CLEAR until IDLE; CLEAR shows eng_rst=1 for one cycle.
REQ-041 abort after 3 results in SORT -> next cycle IDLE, out_valid=0, eng_rst pulse; new job of 8 loads sorts correctly.
REQ-042 rst=0 for 1 cycle mid-DRAIN -> all outputs at REQ-035 values asynchronously, no further out_valid.

Source files
------------

// File: rtl/sort_sequencer.sv
// sort_sequencer: collects ELEMENT_NUM words, presents them bit-plane-wise to an
// external sorting engine, and streams the engine's emitted indices (with their
// original values) out through a first-in-first-out result queue.
module sort_sequencer #(
    parameter int unsigned ELEMENT_NUM      = 8,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned LOG2_ELEMENT_NUM = 3,
    parameter int unsigned LOG2_DATA_WIDTH  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    input  logic                        abort,
    output logic                        eng_rst,
    output logic                        eng_flag,
    input  logic [LOG2_DATA_WIDTH-1:0]  eng_bit_addr,
    output logic [ELEMENT_NUM-1:0]      eng_bit_data,
    input  logic [LOG2_ELEMENT_NUM-1:0] eng_le_addr,
    input  logic                        eng_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy
);

    localparam int unsigned IDX_W = LOG2_ELEMENT_NUM;
    localparam int unsigned CNT_W = LOG2_ELEMENT_NUM + 1;
    localparam int unsigned BIT_W = LOG2_DATA_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENT_NUM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ELEMENT_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SORT,
        S_DRAIN
    } state_e;

    // Control state
    state_e           state_q, state_d;
    logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    // Result queue bookkeeping
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    // Registered outputs
    logic in_ready_q, in_ready_d;
    logic eng_rst_q, eng_rst_d;
    logic eng_flag_q, eng_flag_d;
    logic busy_q, busy_d;

    // Storage: transposed bit planes for the engine, full words for readout
    logic [ELEMENT_NUM-1:0] plane_q [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]  elem_q  [ELEMENT_NUM];
    logic [IDX_W-1:0]       fifo_q  [ELEMENT_NUM];

    logic accept;
    logic store;
    logic push;
    logic pop;
    logic fifo_empty;
    logic fifo_full;

    // Circular pointer advance that also works for non-power-of-two depths
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IDX_W'(1);
    endfunction

    // Handshake qualifiers
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign accept     = in_valid && in_ready_q;
    assign store      = accept && !abort;
    assign pop        = out_valid && out_ready;
    assign push       = (state_q == S_SORT) && eng_valid && (!fifo_full || pop);

    // Result queue pointer/count update; abort empties the queue
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (abort) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    // Next-state and next-output logic for the job sequencer
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        res_cnt_d  = res_cnt_q;

        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (load_cnt_q == LAST_IDX) begin
                        state_d    = S_CLEAR;
                        load_cnt_d = '0;
                    end else begin
                        state_d    = S_LOAD;
                        load_cnt_d = load_cnt_q + IDX_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                state_d   = S_SORT;
                res_cnt_d = '0;
            end
            S_SORT: begin
                if (eng_valid) begin
                    res_cnt_d = res_cnt_q + CNT_W'(1);
                    if (res_cnt_d == FULL_CNT) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_d == '0) begin
                    state_d   = S_IDLE;
                    res_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                load_cnt_d = '0;
                res_cnt_d  = '0;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            load_cnt_d = '0;
            res_cnt_d  = '0;
        end

        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        eng_flag_d = (state_d != S_SORT);
        eng_rst_d  = (state_d == S_CLEAR) || abort;
        busy_d     = (state_d != S_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            res_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            in_ready_q <= 1'b1;
            eng_rst_q  <= 1'b1;
            eng_flag_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            res_cnt_q  <= res_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            in_ready_q <= in_ready_d;
            eng_rst_q  <= eng_rst_d;
            eng_flag_q <= eng_flag_d;
            busy_q     <= busy_d;
        end
    end

    // Element, bit-plane and result-queue storage (contents need no reset)
    always_ff @(posedge clk) begin
        if (store) begin
            elem_q[load_cnt_q] <= in_data;
            for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
                plane_q[BIT_W'(b)][load_cnt_q] <= in_data[BIT_W'(b)];
            end
        end
        if (push && !abort) begin
            fifo_q[wr_ptr_q] <= eng_le_addr;
        end
    end

    // Output mapping; head fields read as zero while the queue is empty
    assign in_ready     = in_ready_q;
    assign eng_rst      = eng_rst_q;
    assign eng_flag     = eng_flag_q;
    assign busy         = busy_q;
    assign eng_bit_data = plane_q[eng_bit_addr];
    assign out_valid    = !fifo_empty;
    assign out_idx      = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    assign out_data     = fifo_empty ? '0 : elem_q[fifo_q[rd_ptr_q]];

endmodule

// File: tb/tb_sort_sequencer.sv
`timescale 1ns/1ps
// tb_sort_sequencer: table-driven and randomized jobs against a behavioural
// model of the expected result order, plus abort and mid-drain reset sequences.
module tb_sort_sequencer;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned LN = 3;
    localparam int unsigned LD = 3;

    typedef logic [DW-1:0] val_arr_t [N];
    typedef logic [LN-1:0] idx_arr_t [N];

    typedef struct {
        val_arr_t vals;
        idx_arr_t exp_idx;
        int       ready_mode;  // 0 always ready, 1 random, 2 hold until drain
        bit       toggle;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          abort = 1'b0;
    logic          eng_rst;
    logic          eng_flag;
    logic [LD-1:0] eng_bit_addr = '0;
    logic [N-1:0]  eng_bit_data;
    logic [LN-1:0] eng_le_addr = '0;
    logic          eng_valid = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LN-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          busy;

    int checks = 0;
    int passed = 0;

    sort_sequencer #(
        .ELEMENT_NUM     (N),
        .DATA_WIDTH      (DW),
        .LOG2_ELEMENT_NUM(LN),
        .LOG2_DATA_WIDTH (LD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .abort       (abort),
        .eng_rst     (eng_rst),
        .eng_flag    (eng_flag),
        .eng_bit_addr(eng_bit_addr),
        .eng_bit_data(eng_bit_data),
        .eng_le_addr (eng_le_addr),
        .eng_valid   (eng_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected engine order: descending value, equal values by ascending index
    function automatic void model_order(input val_arr_t v, output idx_arr_t r);
        bit used [N];
        int best;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int k = 0; k < N; k++) begin
            best = -1;
            for (int e = 0; e < N; e++)
                if (!used[e] && (best < 0 || v[e] > v[best])) best = e;
            used[best] = 1'b1;
            r[k] = LN'(best);
        end
    endfunction

    // Offer the N words; returns at the negedge where the DUT sits in CLEAR
    task automatic do_load(input val_arr_t vals, input bit toggle);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (toggle && k > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            @(negedge clk);
            if (!in_ready) bad++;
            in_valid    = 1'b1;
            in_data     = vals[k];
            eng_valid   = 1'($urandom_range(0, 1));
            eng_le_addr = LN'($urandom);
        end
        @(negedge clk);
        check("load_in_ready", bad, 0);
        check("clear_eng_rst", eng_rst, 1);
        check("clear_eng_flag", eng_flag, 1);
        check("clear_in_ready", in_ready, 0);
        check("clear_busy", busy, 1);
        in_valid    = 1'b1;
        in_data     = 8'hAA;
        eng_valid   = 1'b1;
        eng_le_addr = '0;
    endtask

    // Step into SORT, read back every bit plane as the engine would, derive its order
    task automatic enter_sort(input val_arr_t vals, output idx_arr_t order);
        val_arr_t got;
        int mism;
        @(negedge clk);
        in_valid  = 1'b0;
        eng_valid = 1'b0;
        check("sort_eng_flag", eng_flag, 0);
        check("sort_eng_rst", eng_rst, 0);
        check("sort_out_valid", out_valid, 0);
        for (int b = 0; b < DW; b++) begin
            eng_bit_addr = LD'(b);
            #1;
            for (int e = 0; e < N; e++) got[e][b] = eng_bit_data[e];
        end
        mism = 0;
        for (int e = 0; e < N; e++) if (got[e] !== vals[e]) mism++;
        check("plane_readback", mism, 0);
        model_order(got, order);
    endtask

    task automatic run_job(input val_arr_t vals, input idx_arr_t exp_idx,
                           input int ready_mode, input bit toggle);
        idx_arr_t      order;
        logic [LN-1:0] exp_q [$];
        logic [LN-1:0] e;
        int            emitted, popped, cyc, drain_iters, in_ready_bad;
        bit            in_drain;
        do_load(vals, toggle);
        enter_sort(vals, order);
        for (int i = 0; i < N; i++) exp_q.push_back(exp_idx[i]);
        emitted = 0; popped = 0; cyc = 0; drain_iters = 0; in_ready_bad = 0; in_drain = 1'b0;
        while (popped < N && cyc < 4000) begin
            if (in_ready) in_ready_bad++;
            if (emitted == N && !in_drain) begin
                in_drain = 1'b1;
                check("drain_eng_flag", eng_flag, 1);
                if (ready_mode == 2) check("hold_out_valid", out_valid, 1);
            end
            if (in_drain) drain_iters++;
            if (emitted < N && (ready_mode == 0 || $urandom_range(0, 3) != 0)) begin
                eng_valid   = 1'b1;
                eng_le_addr = order[emitted];
                emitted++;
            end else begin
                eng_valid   = 1'b0;
                eng_le_addr = LN'($urandom);
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = in_drain;
            endcase
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_idx", out_idx, e);
                check("out_data", out_data, vals[e]);
                popped++;
            end
            @(negedge clk);
            cyc++;
        end
        eng_valid = 1'b0;
        out_ready = 1'b0;
        check("job_done", popped, N);
        if (ready_mode == 2) check("drain_pop_cycles", drain_iters, N);
        check("end_busy", busy, 0);
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_eng_flag", eng_flag, 1);
        check("in_ready_low_during_job", in_ready_bad, 0);
    endtask

    initial begin
        vec_t     vecs [4];
        val_arr_t v;
        idx_arr_t x;
        idx_arr_t order;
        int       bad;

        vecs[0].vals    = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0};
        vecs[0].exp_idx = '{3'd2, 3'd4, 3'd0, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        vecs[0].ready_mode = 0; vecs[0].toggle = 1'b0;
        vecs[1].vals    = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        vecs[1].exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        vecs[1].ready_mode = 1; vecs[1].toggle = 1'b1;
        vecs[2].vals    = '{8'd0, 8'd255, 8'd128, 8'd127, 8'd1, 8'd254, 8'd0, 8'd255};
        vecs[2].exp_idx = '{3'd1, 3'd7, 3'd5, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6};
        vecs[2].ready_mode = 2; vecs[2].toggle = 1'b0;
        vecs[3].vals    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        vecs[3].exp_idx = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[3].ready_mode = 2; vecs[3].toggle = 1'b1;

        // Reset values, observed while reset is held
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_eng_rst", eng_rst, 1);
        check("rst_eng_flag", eng_flag, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_eng_rst", eng_rst, 0);
        check("idle_in_ready", in_ready, 1);

        // Directed vectors
        for (int i = 0; i < 4; i++)
            run_job(vecs[i].vals, vecs[i].exp_idx, vecs[i].ready_mode, vecs[i].toggle);

        // Randomized jobs against the model
        for (int j = 0; j < 6; j++) begin
            for (int e = 0; e < N; e++)
                v[e] = (j % 2 == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            model_order(v, x);
            run_job(v, x, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Abort after three results in SORT
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        do_load(v, 1'b0);
        enter_sort(v, order);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eng_valid   = 1'b1;
            eng_le_addr = order[i];
            @(negedge clk);
        end
        eng_valid = 1'b0;
        check("abort_pre_out_valid", out_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_eng_rst", eng_rst, 1);
        check("abort_eng_flag", eng_flag, 1);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        check("abort_eng_rst_release", eng_rst, 0);
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        model_order(v, x);
        run_job(v, x, 1, 1'b0);

        // Reset pulse in the middle of DRAIN
        for (int e = 0; e < N; e++) v[e] = DW'($urandom_range(0, 15));
        model_order(v, x);
        do_load(v, 1'b0);
        enter_sort(v, order);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            eng_valid   = 1'b1;
            eng_le_addr = order[i];
            @(negedge clk);
        end
        eng_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("mid_drain_idx", out_idx, x[i]);
            @(negedge clk);
        end
        #3 rst = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_eng_rst", eng_rst, 1);
        check("async_rst_eng_flag", eng_flag, 1);
        check("async_rst_out_idx", out_idx, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("post_rst_no_out_valid", bad, 0);
        out_ready = 1'b0;
        for (int e = 0; e < N; e++) v[e] = DW'($urandom);
        model_order(v, x);
        run_job(v, x, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
